// File: rtl/cv32e40s_sffr_checker.sv
// Checker for hardened (sffr) register banks: compares each primary flop with
// its complemented shadow copy, keeps a decaying error count and raises minor
// (per-event) and major (sticky lock) alerts.
module cv32e40s_sffr_checker #(
    parameter int WIDTH         = 8,
    parameter int ERR_THRESHOLD = 3,
    parameter int DECAY_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 2,
    localparam int CNT_W        = $clog2(ERR_THRESHOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] q_shadow_i,
    input  logic             clr_req_i,
    output logic             clr_ack_o,
    output logic             alert_minor_o,
    output logic             alert_major_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [WIDTH-1:0] err_bits_o
);

    localparam int CL_W = $clog2(DECAY_CYCLES + 1);
    localparam logic [CNT_W:0]  THR_EXT   = (CNT_W+1)'(ERR_THRESHOLD);
    localparam logic [CNT_W-1:0] THR_CNT  = CNT_W'(ERR_THRESHOLD);
    localparam logic [CL_W-1:0] CLEAN_TOP = CL_W'(DECAY_CYCLES - 1);
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [CL_W-1:0]  clean_q, clean_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic             minor_q, minor_d;
    logic             major_q, major_d;
    logic             ack_q, ack_d;

    // A bit pair mismatches when primary and shadow are equal (not complementary).
    logic [WIDTH-1:0] mm_vec;
    logic             mismatch;
    logic             comparing;
    logic             counted;
    logic             lock_go;
    logic             clr_go;
    logic [CNT_W:0]   cnt_inc;

    assign mm_vec    = q_i ~^ q_shadow_i;
    assign mismatch  = |mm_vec;
    assign comparing = (state_q == ST_CHECK) || (state_q == ST_LOCKED);
    assign counted   = (state_q == ST_CHECK) && mismatch;
    assign cnt_inc   = {1'b0, err_cnt_q} + (CNT_W+1)'(1);
    assign lock_go   = counted && (cnt_inc >= THR_EXT);
    // Lock takes priority over a clear arriving on the same edge.
    assign clr_go    = clr_req_i && !ack_q && (state_q != ST_LOCKED) && !lock_go;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; LOCKED is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (en_i) begin
                    state_d = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
                end
            end
            ST_SETTLE: begin
                if (!en_i) begin
                    state_d = ST_OFF;
                end else if (settle_q == 4'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (lock_go) begin
                    state_d = ST_LOCKED;
                end else if (!en_i) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    // Next values of counters, sticky error bits, alerts and clear acknowledge.
    always_comb begin
        settle_d   = settle_q;
        clean_d    = clean_q;
        err_cnt_d  = err_cnt_q;
        err_bits_d = err_bits_q;
        minor_d    = comparing && mismatch;
        major_d    = (state_d == ST_LOCKED);
        ack_d      = ack_q ? clr_req_i : clr_go;

        // Settle counter: loaded on leaving OFF, counts down while settling.
        if (state_q == ST_OFF && state_d == ST_SETTLE) begin
            settle_d = SETTLE_LD;
        end else if (state_q == ST_SETTLE) begin
            settle_d = settle_q - 4'd1;
        end

        // Sticky error bits accumulate whenever the comparison is live.
        if (comparing) begin
            err_bits_d = err_bits_q | mm_vec;
        end

        // Error count: saturating increment, decay after a clean run.
        if (counted) begin
            clean_d = '0;
            if (err_cnt_q != THR_CNT) begin
                err_cnt_d = cnt_inc[CNT_W-1:0];
            end
        end else if (state_q == ST_CHECK) begin
            if (clean_q == CLEAN_TOP) begin
                clean_d = '0;
                if (err_cnt_q != '0) begin
                    err_cnt_d = err_cnt_q - CNT_W'(1);
                end
            end else begin
                clean_d = clean_q + CL_W'(1);
            end
        end

        // A clear restarts statistics but keeps this cycle's counted mismatch.
        if (clr_go) begin
            clean_d    = '0;
            err_cnt_d  = counted ? CNT_W'(1) : '0;
            err_bits_d = counted ? mm_vec : '0;
        end

        if (state_d != state_q) begin
            clean_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q   <= '0;
            clean_q    <= '0;
            err_cnt_q  <= '0;
            err_bits_q <= '0;
            minor_q    <= 1'b0;
            major_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            settle_q   <= settle_d;
            clean_q    <= clean_d;
            err_cnt_q  <= err_cnt_d;
            err_bits_q <= err_bits_d;
            minor_q    <= minor_d;
            major_q    <= major_d;
            ack_q      <= ack_d;
        end
    end

    assign clr_ack_o     = ack_q;
    assign alert_minor_o = minor_q;
    assign alert_major_o = major_q;
    assign err_cnt_o     = err_cnt_q;
    assign err_bits_o    = err_bits_q;

endmodule

// File: tb/tb_cv32e40s_sffr_checker.sv
// Directed bench for cv32e40s_sffr_checker with default parameters.
module tb_cv32e40s_sffr_checker;

    localparam logic [7:0] Q_VAL   = 8'hA5;
    localparam logic [7:0] SH_GOOD = 8'h5A;
    localparam logic [7:0] SH_B0   = 8'h5B; // bit0 mismatch
    localparam logic [7:0] SH_B2   = 8'h5E; // bit2 mismatch

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic [7:0] q_i;
    logic [7:0] q_shadow_i;
    logic       clr_req_i;
    logic       clr_ack_o;
    logic       alert_minor_o;
    logic       alert_major_o;
    logic [1:0] err_cnt_o;
    logic [7:0] err_bits_o;

    int checks   = 0;
    int failures = 0;

    cv32e40s_sffr_checker #(
        .WIDTH(8), .ERR_THRESHOLD(3), .DECAY_CYCLES(16), .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .q_i(q_i), .q_shadow_i(q_shadow_i),
        .clr_req_i(clr_req_i), .clr_ack_o(clr_ack_o),
        .alert_minor_o(alert_minor_o), .alert_major_o(alert_major_o),
        .err_cnt_o(err_cnt_o), .err_bits_o(err_bits_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one clock edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ack, input logic mn, input logic mj,
                           input logic [1:0] cnt, input logic [7:0] bits);
        chk({tag, ".ack"},   32'(clr_ack_o),     32'(ack));
        chk({tag, ".minor"}, 32'(alert_minor_o), 32'(mn));
        chk({tag, ".major"}, 32'(alert_major_o), 32'(mj));
        chk({tag, ".cnt"},   32'(err_cnt_o),     32'(cnt));
        chk({tag, ".bits"},  32'(err_bits_o),    32'(bits));
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; q_i = Q_VAL; q_shadow_i = SH_GOOD; clr_req_i = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

        // Mismatch while OFF is ignored.
        q_shadow_i = SH_B0;
        step();
        chk_all("off_mm", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

        // Enable with mismatch during both settle cycles: still ignored.
        en_i = 1'b1;
        step();                    // OFF -> SETTLE
        step();                    // settle cycle 1 (mismatch present)
        chk_all("settle1", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        step();                    // settle cycle 2 -> CHECK
        chk_all("settle2", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

        // First CHECK cycle with bit0 mismatch.
        step();
        chk_all("first_mm", 1'b0, 1'b1, 1'b0, 2'd1, 8'h01);
        q_shadow_i = SH_GOOD;
        step();                    // clean 1
        chk("pulse_end", 32'(alert_minor_o), 32'd0);
        for (int i = 0; i < 14; i++) step();   // clean 2..15
        chk("decay_not_yet", 32'(err_cnt_o), 32'd1);
        step();                    // clean 16
        chk("decay_cnt", 32'(err_cnt_o), 32'd0);
        chk("decay_bits", 32'(err_bits_o), 32'h01);

        // Mismatch, 14 clean, mismatch on the 15th: no decay in between.
        q_shadow_i = SH_B0; step();
        q_shadow_i = SH_GOOD;
        for (int i = 0; i < 14; i++) step();
        q_shadow_i = SH_B0; step();
        chk("restart_cnt", 32'(err_cnt_o), 32'd2);

        // Clear handshake on a clean cycle.
        q_shadow_i = SH_GOOD; clr_req_i = 1'b1;
        step();
        chk_all("clr_rise", 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        q_shadow_i = SH_B0;        // req held: mismatch counts, no second clear
        step();
        chk_all("clr_hold_mm", 1'b1, 1'b1, 1'b0, 2'd1, 8'h01);
        q_shadow_i = SH_GOOD;
        step();
        chk("clr_hold_cnt", 32'(err_cnt_o), 32'd1);
        clr_req_i = 1'b0;
        step();
        chk("clr_fall", 32'(clr_ack_o), 32'd0);

        // Clear with a mismatch on the clear edge.
        clr_req_i = 1'b1; q_shadow_i = SH_B2;
        step();
        chk_all("clr_mm", 1'b1, 1'b1, 1'b0, 2'd1, 8'h04);
        clr_req_i = 1'b0; q_shadow_i = SH_GOOD;
        step();
        chk("clr_mm_fall", 32'(clr_ack_o), 32'd0);

        // Disable: counts retained, mismatch while OFF ignored.
        en_i = 1'b0;
        step();                    // CHECK -> OFF
        q_shadow_i = SH_B0;
        step();
        chk_all("off_retain", 1'b0, 1'b0, 1'b0, 2'd1, 8'h04);

        // Fresh start, then three mismatches; clear collides with the lock.
        rst = 1'b1; q_shadow_i = SH_GOOD;
        step();
        rst = 1'b0; en_i = 1'b1;
        step(); step(); step();    // OFF -> SETTLE -> SETTLE -> CHECK
        q_shadow_i = SH_B0;
        step();
        chk("lock_mm1_cnt", 32'(err_cnt_o), 32'd1);
        step();
        chk_all("lock_mm2", 1'b0, 1'b1, 1'b0, 2'd2, 8'h01);
        clr_req_i = 1'b1;
        step();
        chk_all("lock_mm3", 1'b0, 1'b1, 1'b1, 2'd3, 8'h01);

        // LOCKED: en_i ignored, no ack, comparison still live.
        en_i = 1'b0; q_shadow_i = SH_GOOD;
        step();
        chk_all("locked_clean", 1'b0, 1'b0, 1'b1, 2'd3, 8'h01);
        q_shadow_i = SH_B2;
        step();
        chk_all("locked_mm", 1'b0, 1'b1, 1'b1, 2'd3, 8'h05);

        // Reset out of LOCKED.
        rst = 1'b1; q_shadow_i = SH_GOOD;
        step();
        chk_all("rst_locked", 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        rst = 1'b0; clr_req_i = 1'b0;
        step();
        chk("after_rst_major", 32'(alert_major_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cv32e40s_sffr_checker.md
Name: cv32e40s_sffr_checker

Overview:
- Reader/checker side of the hardened flop scheme: samples a bank of sffr outputs together with their complemented shadow copies, and flags any pair whose bits are not complementary.
- Tracks error history with a saturating, decaying counter.
- Raises a per-event minor alert, and a sticky major alert once a threshold is reached.
- Sits next to the protected register banks; alerts are routed to the alert/controller logic.

Parameters:
- WIDTH, 8, number of protected bit pairs (1..32).
- ERR_THRESHOLD, 3, error count that locks the checker (1..15).
- DECAY_CYCLES, 16, consecutive clean CHECK cycles needed to decrement the error count (>=1).
- SETTLE_CYCLES, 2, cycles after enable during which mismatches are ignored (0..15).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- en_i  input  1  checker enable.
- q_i  input  WIDTH  primary sffr outputs.
- q_shadow_i  input  WIDTH  shadow sffr outputs; expected to equal ~q_i.
- clr_req_i  input  1  statistics clear request (4-phase).
- clr_ack_o  output  1  clear acknowledge.
- alert_minor_o  output  1  registered pulse, one per mismatching CHECK cycle.
- alert_major_o  output  1  sticky lock alert.
- err_cnt_o  output  CNT_W  current error count, where CNT_W = $clog2(ERR_THRESHOLD+1).
- err_bits_o  output  WIDTH  sticky OR of mismatching bit positions.

Behaviour:
- Reset is synchronous, active-high, and the only way to leave LOCKED. On reset:
  - state=OFF, all counters 0.
  - clr_ack_o=0, alert_minor_o=0, alert_major_o=0, err_cnt_o=0, err_bits_o=0.
- Definitions (combinational):
  - mm_vec = q_i ~^ q_shadow_i.
  - mismatch = |mm_vec.
- State machine: OFF, SETTLE, CHECK, LOCKED.
  - OFF:
    - en_i=1 and SETTLE_CYCLES>0 -> SETTLE, settle counter loaded with SETTLE_CYCLES.
    - en_i=1 and SETTLE_CYCLES=0 -> CHECK.
  - SETTLE:
    - Counter decrements each cycle; mismatches are ignored.
    - en_i=0 -> OFF.
    - Counter==1 -> CHECK, so CHECK starts exactly SETTLE_CYCLES cycles after entry.
  - CHECK:
    - en_i=0 -> OFF; err_cnt and err_bits are retained.
    - Mismatch with err_cnt+1 >= ERR_THRESHOLD -> LOCKED.
  - LOCKED:
    - Terminal until rst; en_i is ignored.
    - alert_major_o=1 from the cycle after entry onward.
    - Comparison continues: alert_minor_o and err_bits_o keep updating; err_cnt_o holds at ERR_THRESHOLD.
- CHECK/LOCKED comparison is registered, with 1-cycle latency:
  - alert_minor_o(t+1) = mismatch(t).
  - err_bits_o |= mm_vec.
- Error counter:
  - Increments on each mismatching CHECK cycle and saturates at ERR_THRESHOLD.
- Decay:
  - In CHECK, a clean counter counts consecutive mismatch-free cycles.
  - When it reaches DECAY_CYCLES: err_cnt decrements if nonzero, and the clean counter restarts from 0.
  - A mismatch, a state change, or a clear zeroes the clean counter.
  - The clean counter is frozen in OFF and SETTLE.
- Clear handshake (4-phase):
  - clr_ack_o rises the cycle after clr_req_i=1 is sampled with clr_ack_o=0 and state!=LOCKED.
  - On that edge: err_cnt <= (counted mismatch this cycle ? 1 : 0) and err_bits <= mm_vec (counted only in CHECK).
  - clr_ack_o stays high while clr_req_i=1 and falls the cycle after clr_req_i=0.
  - Exactly one clear is performed per handshake.
  - In LOCKED, no ack is given; a pending request stays unacknowledged. An ack already high when LOCKED is entered still completes its fall normally.
- Simultaneous events:
  - Clear and a threshold-reaching mismatch on the same edge: lock wins and no clear is applied.
  - en_i falling on a mismatch cycle: the mismatch is still counted (the state is CHECK when sampled).
- Reset mid-operation, including in LOCKED or mid-handshake, returns every output to its reset value on the next edge.

Test Plan:
- Reset, en_i=1, q_i=8'hA5, q_shadow_i=8'h5A, SETTLE_CYCLES=2 -> CHECK entered 2 cycles after enable; alert_minor_o=0 and err_cnt_o=0 throughout.
- In CHECK, force q_shadow_i=8'h5B (bit0 mismatch) for one cycle -> alert_minor_o pulses for 1 cycle, one cycle later; err_cnt_o=1; err_bits_o=8'h01.
- Then 16 clean cycles -> err_cnt_o returns to 0 on the 16th; err_bits_o stays 8'h01. A mismatch at cycle 15 -> the clean count restarts and err_cnt_o=2.
- Three mismatching cycles with ERR_THRESHOLD=3 -> alert_major_o=1 from the cycle after the third. Then: en_i=0 has no effect; clr_req_i=1 gets no ack; err_cnt_o=3; rst=1 for 1 cycle clears everything.
- err_cnt_o=2, then raise clr_req_i on a clean cycle -> clr_ack_o=1 the next cycle with err_cnt_o=0 and err_bits_o=0. Holding req high gives no second clear; dropping req drops ack one cycle later.
- Mismatch injected during SETTLE and while OFF -> no alert, err_cnt_o unchanged. Mismatch injected in the clear-edge cycle -> err_cnt_o=1 after the clear.
